// File: rtl/ct_vfdsu_pkg.sv
// Shared definitions for the scalar VFDSU divide/sqrt sequencing logic.
// Holds state encoding, func field indices and default iteration counts.
package ct_vfdsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EX1  = 3'd1,
        ST_ITER = 3'd2,
        ST_RND  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    localparam int FUNC_DIV    = 0;
    localparam int FUNC_SQRT   = 1;
    localparam int FUNC_SINGLE = 15;
    localparam int FUNC_DOUBLE = 16;

    localparam int DBL_ITER_DEF = 28;
    localparam int SGL_ITER_DEF = 13;

endpackage

// File: rtl/ct_vfdsu_srt_cnt.sv
// 5-bit SRT iteration counter: sync clear, load, decrement, zero flag.
module ct_vfdsu_srt_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [4:0] load_val_i,
    input  logic       dec_i,
    output logic [4:0] cnt_o,
    output logic       zero_o
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 5'd0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i)
            cnt_d = cnt_q - 5'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= 5'd0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 5'd0);

endmodule

// File: rtl/ct_vfdsu_scalar_ctrl.sv
// Sequencing controller for the scalar VFDSU divide/sqrt datapath.
// Walks one op through EX1 / SRT iterate / round / write-back hold.
module ct_vfdsu_scalar_ctrl
    import ct_vfdsu_pkg::*;
#(
    parameter int DBL_ITER = DBL_ITER_DEF,
    parameter int SGL_ITER = SGL_ITER_DEF
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        idu_vfpu_rf_pipex_sel,
    input  logic [19:0] idu_vfpu_rf_pipex_func,
    input  logic        ex1_special_vld,
    input  logic        rtu_yy_xx_flush,
    input  logic        rbus_vfdsu_wb_grant,
    output logic        ctrl_idu_busy,
    output logic        ex1_pipedown,
    output logic        ex2_pipedown,
    output logic        ex3_pipedown,
    output logic        ex1_data_clk_en,
    output logic        ex2_data_clk_en,
    output logic        ex3_data_clk_en,
    output logic        srt_first_round,
    output logic        srt_iter_vld,
    output logic [4:0]  iter_cnt,
    output logic        ex4_result_vld
);

    localparam logic [4:0] DBL_LD = 5'(DBL_ITER - 1);
    localparam logic [4:0] SGL_LD = 5'(SGL_ITER - 1);

    state_e     state_q;
    state_e     state_d;
    logic       busy_q;
    logic       dbl_q;
    logic       first_q;
    logic       issue_ok;
    logic       flush;
    logic       cnt_zero;
    logic       cnt_load;
    logic       cnt_dec;
    logic [4:0] cnt_ld_val;
    logic [4:0] cnt_val;
    logic       unused_func;

    assign flush    = rtu_yy_xx_flush;
    assign issue_ok = idu_vfpu_rf_pipex_sel & ~flush
                    & (idu_vfpu_rf_pipex_func[FUNC_DIV]
                     | idu_vfpu_rf_pipex_func[FUNC_SQRT]);

    // Single-precision bit only matters when double is clear.
    assign unused_func = ^{idu_vfpu_rf_pipex_func[19:17],
                           idu_vfpu_rf_pipex_func[14:2]};

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dbl_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            first_q <= (state_q == ST_EX1) & ~flush;
            if (state_q == ST_IDLE && issue_ok)
                dbl_q <= idu_vfpu_rf_pipex_func[FUNC_DOUBLE];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (issue_ok) state_d = ST_EX1;
            ST_EX1:  state_d = ST_ITER;
            ST_ITER: if (cnt_zero) state_d = ST_RND;
            ST_RND:  state_d = ST_WB;
            ST_WB:   if (rbus_vfdsu_wb_grant) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    always_comb begin
        ex1_pipedown    = 1'b0;
        ex2_pipedown    = 1'b0;
        ex3_pipedown    = 1'b0;
        srt_iter_vld    = 1'b0;
        srt_first_round = 1'b0;
        ex4_result_vld  = 1'b0;
        if (!flush) begin
            unique case (state_q)
                ST_IDLE: ;
                ST_EX1:  ex1_pipedown = 1'b1;
                ST_ITER: begin
                    srt_iter_vld    = 1'b1;
                    srt_first_round = first_q;
                    ex2_pipedown    = cnt_zero;
                end
                ST_RND:  ex3_pipedown   = 1'b1;
                ST_WB:   ex4_result_vld = 1'b1;
                default: ;
            endcase
        end
    end

    assign ex1_data_clk_en = ex1_pipedown;
    assign ex2_data_clk_en = ex2_pipedown;
    assign ex3_data_clk_en = ex3_pipedown;
    assign ctrl_idu_busy   = busy_q;

    assign cnt_ld_val = ex1_special_vld ? 5'd0
                      : (dbl_q ? DBL_LD : SGL_LD);
    assign cnt_load   = (state_q == ST_EX1);
    assign cnt_dec    = (state_q == ST_ITER) & ~cnt_zero;

    ct_vfdsu_srt_cnt u_srt_cnt (
        .clk_i      (forever_cpuclk),
        .rst_i      (cpurst),
        .clr_i      (flush),
        .load_i     (cnt_load),
        .load_val_i (cnt_ld_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    assign iter_cnt = cnt_val;

endmodule

// File: tb/tb_ct_vfdsu_scalar_ctrl.sv
// Bench for ct_vfdsu_scalar_ctrl: fixed vector table, directed
// latency/flush/reset sequences and random traffic vs. a timeline model.
module tb_ct_vfdsu_scalar_ctrl;

    localparam int D = 28;
    localparam int S = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [19:0] func;
    logic        spc;
    logic        flush;
    logic        grant;
    logic        busy, e1p, e2p, e3p, e1c, e2c, e3c;
    logic        first, itv, resv;
    logic [4:0]  cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] smp;

    // Timeline model: active op, cycle offset since issue, iteration count.
    bit m_act;
    int m_k;
    int m_n;
    bit m_dbl;

    always #5 clk = ~clk;

    ct_vfdsu_scalar_ctrl #(.DBL_ITER(D), .SGL_ITER(S)) dut (
        .forever_cpuclk         (clk),
        .cpurst                 (rst),
        .idu_vfpu_rf_pipex_sel  (sel),
        .idu_vfpu_rf_pipex_func (func),
        .ex1_special_vld        (spc),
        .rtu_yy_xx_flush        (flush),
        .rbus_vfdsu_wb_grant    (grant),
        .ctrl_idu_busy          (busy),
        .ex1_pipedown           (e1p),
        .ex2_pipedown           (e2p),
        .ex3_pipedown           (e3p),
        .ex1_data_clk_en        (e1c),
        .ex2_data_clk_en        (e2c),
        .ex3_data_clk_en        (e3c),
        .srt_first_round        (first),
        .srt_iter_vld           (itv),
        .iter_cnt               (cnt),
        .ex4_result_vld         (resv)
    );

    function automatic logic [14:0] ex(input bit b, input bit p1,
        input bit p2, input bit p3, input bit fr, input bit iv,
        input int c, input bit rv);
        logic [4:0] c5;
        c5 = 5'(c);
        return {b, p1, p2, p3, p1, p2, p3, fr, iv, c5, rv};
    endfunction

    function automatic logic [14:0] mexp(input bit fl);
        bit b, p1, p2, p3, fr, iv, rv;
        int c;
        b = 0; p1 = 0; p2 = 0; p3 = 0; fr = 0; iv = 0; rv = 0; c = 0;
        if (m_act) begin
            b = 1;
            if (m_k == 1)
                p1 = 1;
            else if (m_k <= m_n + 1) begin
                iv = 1;
                fr = (m_k == 2);
                c  = m_n + 1 - m_k;
                p2 = (m_k == m_n + 1);
            end else if (m_k == m_n + 2)
                p3 = 1;
            else
                rv = 1;
        end
        if (fl) begin
            p1 = 0; p2 = 0; p3 = 0; fr = 0; iv = 0; rv = 0;
        end
        return ex(b, p1, p2, p3, fr, iv, c, rv);
    endfunction

    task automatic madv(input logic s, input logic [19:0] f,
        input logic sp, input logic fl, input logic gr, input logic rs);
        if (rs || fl)
            m_act = 0;
        else if (!m_act) begin
            if (s && (f[0] || f[1])) begin
                m_act = 1;
                m_k   = 1;
                m_dbl = f[16];
            end
        end else begin
            if (m_k == 1)
                m_n = sp ? 1 : (m_dbl ? D : S);
            if (m_k >= m_n + 3) begin
                if (gr) m_act = 0;
            end else
                m_k++;
        end
    endtask

    task automatic chk(input string nm, input int a, input int e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // One clock: drive, sample on the falling edge, advance the model.
    task automatic cyc(input logic s, input logic [19:0] f,
        input logic sp, input logic fl, input logic gr, input logic rs,
        input bit use_t, input logic [14:0] texp, input string nm);
        logic [14:0] e;
        sel = s; func = f; spc = sp; flush = fl; grant = gr; rst = rs;
        @(negedge clk);
        smp = {busy, e1p, e2p, e3p, e1c, e2c, e3c, first, itv, cnt, resv};
        e = use_t ? texp : mexp(fl);
        n_cmp++;
        if (smp !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, smp, e);
        end
        @(posedge clk);
        madv(s, f, sp, fl, gr, rs);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 20'h0, 0, 0, 0, 0, 0, 15'h0, "idle");
    endtask

    // Issue one op; grant rises after gdly result cycles.
    task automatic run_op(input logic [19:0] f, input logic sp,
        input int gdly, output int lat, output int hold);
        bit gr;
        lat = -1;
        hold = 0;
        gr = (gdly == 0);
        cyc(1, f, 0, 0, 0, 0, 0, 15'h0, "issue");
        for (int i = 1; i < 80; i++) begin
            cyc(0, f, sp, 0, gr, 0, 0, 15'h0, "op");
            if (smp[0]) begin
                if (lat < 0) lat = i;
                hold++;
                if (gr) break;
            end
            gr = (hold >= gdly);
        end
    endtask

    typedef struct {
        logic        s;
        logic [19:0] f;
        logic        sp;
        logic        fl;
        logic        gr;
        logic [14:0] e;
    } vec_t;

    vec_t tab[12];

    localparam logic [19:0] F_DD = 20'h10001;
    localparam logic [19:0] F_SS = 20'h08002;
    localparam logic [19:0] F_NO = 20'h18000;
    localparam logic [19:0] F_BD = 20'h18001;

    int lat, hold;
    logic [31:0] r;
    logic [19:0] rf;

    initial begin
        tab[0]  = '{1, F_DD, 0, 0, 0, ex(0,0,0,0,0,0,0,0)};
        tab[1]  = '{0, 0,    1, 0, 0, ex(1,1,0,0,0,0,0,0)};
        tab[2]  = '{1, F_SS, 0, 0, 0, ex(1,0,1,0,1,1,0,0)};
        tab[3]  = '{0, 0,    0, 0, 0, ex(1,0,0,1,0,0,0,0)};
        tab[4]  = '{0, 0,    0, 0, 0, ex(1,0,0,0,0,0,0,1)};
        tab[5]  = '{0, 0,    0, 0, 1, ex(1,0,0,0,0,0,0,1)};
        tab[6]  = '{1, F_NO, 0, 0, 0, ex(0,0,0,0,0,0,0,0)};
        tab[7]  = '{1, F_SS, 0, 1, 0, ex(0,0,0,0,0,0,0,0)};
        tab[8]  = '{0, 0,    0, 0, 0, ex(0,0,0,0,0,0,0,0)};
        tab[9]  = '{1, F_SS, 0, 0, 0, ex(0,0,0,0,0,0,0,0)};
        tab[10] = '{1, F_DD, 1, 1, 0, ex(1,0,0,0,0,0,0,0)};
        tab[11] = '{0, 0,    0, 0, 0, ex(0,0,0,0,0,0,0,0)};

        sel = 0; func = 0; spc = 0; flush = 0; grant = 0; rst = 1;
        m_act = 0; m_k = 0; m_n = 0; m_dbl = 0;
        repeat (3) @(posedge clk);
        #1;

        foreach (tab[i])
            cyc(tab[i].s, tab[i].f, tab[i].sp, tab[i].fl, tab[i].gr, 0,
                1, tab[i].e, $sformatf("tab%0d", i));

        run_op(F_DD, 0, 0, lat, hold);
        chk("dbl_lat", lat, 31);
        chk("dbl_hold", hold, 1);
        idle(1);
        chk("dbl_busy_after", int'(smp[14]), 0);

        run_op(F_SS, 0, 5, lat, hold);
        chk("sgl_lat", lat, 16);
        chk("sgl_hold", hold, 6);
        run_op(F_BD, 1, 0, lat, hold);
        chk("spc_lat", lat, 4);

        // Flush ten cycles into a double op, then re-issue at once.
        cyc(1, F_DD, 0, 0, 0, 0, 0, 15'h0, "fl_issue");
        for (int i = 1; i < 10; i++)
            cyc(i[0], F_SS, 0, 0, 1, 0, 0, 15'h0, "fl_iter");
        cyc(0, 0, 0, 1, 0, 0, 0, 15'h0, "fl_cyc");
        run_op(F_SS, 0, 0, lat, hold);
        chk("post_flush_lat", lat, 16);

        // Flush coincident with grant in write-back.
        cyc(1, F_SS, 0, 0, 0, 0, 0, 15'h0, "fg_issue");
        for (int i = 1; i < 16; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 15'h0, "fg_run");
        cyc(0, 0, 0, 1, 1, 0, 0, 15'h0, "fg_both");
        idle(1);
        chk("fg_busy", int'(smp[14]), 0);

        // Reset twenty cycles into a double op.
        cyc(1, F_DD, 0, 0, 0, 0, 0, 15'h0, "rs_issue");
        for (int i = 1; i < 20; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 15'h0, "rs_run");
        cyc(0, 0, 0, 0, 0, 1, 0, 15'h0, "rs_cyc");
        cyc(0, 0, 0, 0, 0, 0, 1, 15'h0, "rs_after");
        run_op(F_DD, 0, 0, lat, hold);
        chk("post_rst_lat", lat, 31);

        for (int i = 0; i < 4000; i++) begin
            r  = $urandom;
            rf = r[19:0];
            cyc(($urandom % 6) == 0, rf, ($urandom % 4) == 0,
                ($urandom % 60) == 0, ($urandom % 3) != 0,
                ($urandom % 500) == 0, 0, 15'h0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
